majority_voter_pipe: RTL

Parametrised successor to the fixed 3-input majority gate. It takes a WIDTH-bit vote vector per sample and computes the spatial vote: the bit count compared against a programmable threshold. It also keeps a sliding window of the last DEPTH spatial votes and can output a temporal majority over that window, for glitch-filtered decisions. The block sits between redundant sensor or channel inputs and downstream control logic, with a 2-stage registered pipeline and valid qualification.

---
 rtl/majority_pkg.sv | 13 +
 rtl/majority_voter_pipe_popcount.sv | 21 ++
 rtl/majority_voter_pipe.sv | 139 +++++++++++++
 3 files changed

// File: rtl/majority_pkg.sv
// Shared definitions for the majority voter: mode encoding and the helper
// that sizes the bit-count and window-count fields.
package majority_pkg;

  localparam logic MODE_SPATIAL  = 1'b0;
  localparam logic MODE_TEMPORAL = 1'b1;

  // Bits needed to hold a count in the range 0..n (at least one bit).
  function automatic int count_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/majority_voter_pipe_popcount.sv
// Combinational population count of a vote vector; result is wide enough
// to hold WIDTH itself, so it can never overflow.
module popcount
  import majority_pkg::*;
#(
  parameter  int WIDTH = 3,
  localparam int CW    = count_width(WIDTH)
) (
  input  logic [WIDTH-1:0] i_data,
  output logic [CW-1:0]    o_count
);

  // Sum the individual vote bits.
  always_comb begin
    o_count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      o_count = o_count + CW'(i_data[i]);
    end
  end

endmodule

// File: rtl/majority_voter_pipe.sv
// Two-stage majority voter. Stage 1 registers the spatial vote of the
// incoming sample; stage 2 maintains a sliding window of the last DEPTH
// spatial votes and registers either the spatial or the temporal decision.
module majority_voter_pipe
  import majority_pkg::*;
#(
  parameter  int WIDTH  = 3,
  parameter  int THRESH = (WIDTH / 2) + 1,
  parameter  int DEPTH  = 5,
  localparam int CW     = count_width(WIDTH),
  localparam int DW     = count_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             mode,
  input  logic             clear,
  output logic             out_valid,
  output logic             y,
  output logic [CW-1:0]    count,
  output logic [DW-1:0]    win_count,
  output logic             window_full
);

  // Stage 1 state
  logic          r_v1;
  logic          r_s1;
  logic          r_mode1;
  logic [CW-1:0] r_cnt1;

  // Stage 2 state
  logic [DEPTH-1:0] r_hist;         // bit 0 newest, bit DEPTH-1 oldest
  logic [DW-1:0]    r_fill;
  logic [DW-1:0]    r_win_count;
  logic             r_window_full;
  logic             r_out_valid;
  logic             r_y;
  logic [CW-1:0]    r_count;

  // Combinational helpers
  logic [CW-1:0]    w_cnt;
  logic             w_spatial;
  logic             w_accept;
  logic             w_drop;
  logic [DW-1:0]    w_win_next;
  logic [DW-1:0]    w_fill_next;
  logic             w_full_next;
  logic             w_temporal_y;
  logic [DEPTH-1:0] w_hist_next;

  popcount #(
    .WIDTH (WIDTH)
  ) u_popcount (
    .i_data  (in_data),
    .o_count (w_cnt)
  );

  assign w_spatial = (w_cnt >= CW'(THRESH));
  assign w_accept  = in_valid & ~clear;

  // History shift: the new spatial vote enters at bit 0.
  assign w_hist_next[0] = r_s1;
  for (genvar gi = 1; gi < DEPTH; gi++) begin : g_shift
    assign w_hist_next[gi] = r_hist[gi-1];
  end

  // The oldest vote leaves in the same update the new one arrives, so the
  // count never transiently exceeds DEPTH. Modular arithmetic in DW bits is
  // exact because the true result always lies in 0..DEPTH.
  assign w_drop       = r_window_full & r_hist[DEPTH-1];
  assign w_win_next   = r_win_count + DW'(r_s1) - DW'(w_drop);
  assign w_fill_next  = (r_fill == DW'(DEPTH)) ? r_fill : r_fill + DW'(1);
  assign w_full_next  = (w_fill_next == DW'(DEPTH));
  assign w_temporal_y = (w_win_next > DW'(DEPTH / 2));

  // Stage 1: capture popcount, spatial vote and mode of an accepted sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1    <= 1'b0;
      r_s1    <= 1'b0;
      r_mode1 <= 1'b0;
      r_cnt1  <= '0;
    end else begin
      r_v1 <= w_accept;
      if (w_accept) begin
        r_s1    <= w_spatial;
        r_mode1 <= mode;
        r_cnt1  <= w_cnt;
      end
    end
  end

  // Stage 2: update the window and register the selected decision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist        <= '0;
      r_fill        <= '0;
      r_win_count   <= '0;
      r_window_full <= 1'b0;
      r_out_valid   <= 1'b0;
      r_y           <= 1'b0;
      r_count       <= '0;
    end else if (clear) begin
      r_hist        <= '0;
      r_fill        <= '0;
      r_win_count   <= '0;
      r_window_full <= 1'b0;
      r_out_valid   <= 1'b0;
      r_y           <= 1'b0;
    end else if (r_v1) begin
      r_hist        <= w_hist_next;
      r_fill        <= w_fill_next;
      r_win_count   <= w_win_next;
      r_window_full <= w_full_next;
      if (r_mode1 == MODE_SPATIAL) begin
        r_out_valid <= 1'b1;
        r_y         <= r_s1;
        r_count     <= r_cnt1;
      end else begin
        // Temporal decisions are only meaningful once the window is full.
        r_out_valid <= w_full_next;
        if (w_full_next) begin
          r_y     <= w_temporal_y;
          r_count <= r_cnt1;
        end
      end
    end else begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid   = r_out_valid;
  assign y           = r_y;
  assign count       = r_count;
  assign win_count   = r_win_count;
  assign window_full = r_window_full;

endmodule
